// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: snake game state machine with debounced start key and paced score-add pulses
module snake_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DIE_HOLD_CYCLES = 150_000_000,
  parameter int ADD_HIGH_CYCLES = 4,
  parameter int ADD_LOW_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       hit_wall,
  input  logic       hit_body,
  input  logic       food_eaten,
  output logic [1:0] status,
  output logic       add,
  output logic       game_active
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(DIE_HOLD_CYCLES);
  localparam int AW = $clog2(ADD_HIGH_CYCLES > ADD_LOW_CYCLES ? ADD_HIGH_CYCLES : ADD_LOW_CYCLES);
  typedef enum logic [1:0] {RESTART = 2'b00, START = 2'b01, PLAY = 2'b10, DIE = 2'b11} state_t;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} seq_t;
  state_t state;
  seq_t seq;
  logic key_s1, key_s2, key_db, key_db_q;
  logic key_press, hit, clr, accept, start_add, inc;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] die_cnt;
  logic [AW-1:0] add_cnt;
  logic [1:0] pending;
  assign status = state;
  // Derived per-cycle events: key edge, collision, food acceptance, pulse launch
  always_comb begin
    key_press = key_db & ~key_db_q;
    hit = hit_wall | hit_body;
    clr = (state == PLAY) & hit;
    accept = (state == PLAY) & food_eaten & ~hit;
    start_add = (seq == IDLE) & (pending != 2'd0) & ~clr;
    inc = accept & ((pending != 2'd3) | start_add);
  end
  // Two-flop synchroniser for the raw key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= key_start;
      key_s2 <= key_s1;
    end
  end
  // Debounce: accept a new key level only after it has been stable long enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      key_db <= 1'b0;
      key_db_q <= 1'b0;
    end else begin
      key_db_q <= key_db;
      if (key_s2 == key_db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + DW'(1);
    end
  end
  // Game FSM with registered game_active tracking PLAY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESTART;
      game_active <= 1'b0;
      die_cnt <= '0;
    end else begin
      case (state)
        RESTART: if (key_press) state <= START;
        START: if (!key_db) begin
          state <= PLAY;
          game_active <= 1'b1;
        end
        PLAY: if (hit) begin
          state <= DIE;
          game_active <= 1'b0;
          die_cnt <= '0;
        end
        DIE: if (die_cnt == HW'(DIE_HOLD_CYCLES - 1)) state <= RESTART;
             else die_cnt <= die_cnt + HW'(1);
      endcase
    end
  end
  // Pending food counter and add pulse sequencer; pulses in flight always finish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq <= IDLE;
      add <= 1'b0;
      add_cnt <= '0;
      pending <= 2'd0;
    end else begin
      pending <= clr ? 2'd0 : pending + {1'b0, inc} - {1'b0, start_add};
      case (seq)
        IDLE: if (start_add) begin
          seq <= HIGH;
          add <= 1'b1;
          add_cnt <= '0;
        end
        HIGH: if (add_cnt == AW'(ADD_HIGH_CYCLES - 1)) begin
          seq <= LOW;
          add <= 1'b0;
          add_cnt <= '0;
        end else add_cnt <= add_cnt + AW'(1);
        LOW: if (add_cnt == AW'(ADD_LOW_CYCLES - 1)) seq <= IDLE;
             else add_cnt <= add_cnt + AW'(1);
        default: seq <= IDLE;
      endcase
    end
  end
endmodule
